// File: rtl/inv_subs_layer_seq_pkg.sv
//------------------------------------------------------------------------------
// inv_subs_layer_seq_pkg
// Shared cipher package: block width, sequencer state encoding and the
// inverse 4-bit PRESENT S-box, reused by the decryption round.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

// Fallback so the package still elaborates if Constants.sv is read later.
`ifndef SIZE
`define SIZE 64
`endif

package inv_subs_layer_seq_pkg;

  localparam int c_size = `SIZE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Entry i lives in nibble i: index 0 -> 5, ..., index F -> A.
  localparam logic [15:0][3:0] c_inv_sbox = 64'hA970364BD21C8FE5;

  function automatic logic [3:0] inv_sbox_lookup(input logic [3:0] code);
    return c_inv_sbox[code];
  endfunction

endpackage

`default_nettype wire

// File: rtl/Constants.sv
//------------------------------------------------------------------------------
// Constants
// Shared cipher-wide constants: block width used by every datapath stage.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef CONSTANTS_SV
`define CONSTANTS_SV
`define SIZE 64
`endif

`default_nettype wire

// File: rtl/inv_subs_layer_seq_inv_sbox.sv
//------------------------------------------------------------------------------
// inv_sbox
// Combinational inverse PRESENT S-box: one 4-bit nibble in, one out.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inv_sbox
  import inv_subs_layer_seq_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] plain
);

  // Plain table lookup; no state.
  always_comb begin
    plain = inv_sbox_lookup(code);
  end

endmodule

`default_nettype wire

// File: rtl/inv_subs_layer_seq.sv
//------------------------------------------------------------------------------
// inv_subs_layer_seq
// Sequential inverse substitution layer: inverts all 16 nibbles of a 64-bit
// block, LANES nibbles per clock, behind a valid/ready handshake.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inv_subs_layer_seq
  import inv_subs_layer_seq_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [c_size-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [c_size-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int c_groups   = 16 / LANES;
  localparam int c_cnt_w    = (c_groups > 1) ? $clog2(c_groups) : 1;
  localparam int c_grp_bits = 4 * LANES;
  localparam logic [c_cnt_w-1:0] c_last_grp = c_cnt_w'(c_groups - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_illegal
      $error("inv_subs_layer_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  state_t                r_state;
  state_t                w_next;
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_drain;
  logic [c_size-1:0]     r_work;
  logic [c_grp_bits-1:0] w_sub;
  logic [c_size-1:0]     w_rot;
  logic                  w_accept;

  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign out_data = r_work;

  // The top group of the work register is always the one being substituted;
  // the register rotates left by one group per cycle so after all groups
  // every nibble is back in its original position.
  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      inv_sbox u_inv_sbox (
        .code  (r_work[c_size-1-4*l -: 4]),
        .plain (w_sub[c_grp_bits-1-4*l -: 4])
      );
    end
    if (LANES == 16) begin : g_rot_full
      assign w_rot = w_sub;
    end else begin : g_rot_part
      assign w_rot = {r_work[c_size-1-c_grp_bits:0], w_sub};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: BUSY lingers one cycle past the last group (r_drain) so the
  // accept-to-valid latency is groups+1.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_next = ST_BUSY;
      ST_BUSY: if (r_drain)   w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded straight from state.
  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
  end

  // Work register, group counter and drain flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work  <= '0;
      r_cnt   <= '0;
      r_drain <= 1'b0;
    end else if (w_accept) begin
      r_work  <= in_data;
      r_cnt   <= '0;
      r_drain <= 1'b0;
    end else if (r_state == ST_BUSY && !r_drain) begin
      r_work <= w_rot;
      r_cnt  <= r_cnt + c_cnt_w'(1);
      if (r_cnt == c_last_grp) r_drain <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inv_subs_layer_seq.sv
//------------------------------------------------------------------------------
// tb_inv_subs_layer_seq
// Directed bench for inv_subs_layer_seq with LANES = 1, 4 and 16 side by side.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_inv_subs_layer_seq;

  logic        clk;
  logic        rst_n;
  logic [2:0]  in_valid;
  logic [2:0]  out_ready;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [63:0] in_data  [3];
  logic [63:0] out_data [3];

  int vectors     = 0;
  int miscompares = 0;

  inv_subs_layer_seq #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]));

  inv_subs_layer_seq #(.LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]));

  inv_subs_layer_seq #(.LANES(16)) u_l16 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .out_data(out_data[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected accept-to-valid latency per instance: 16/LANES + 1.
  function automatic int lat_of(input int k);
    return (k == 0) ? 17 : (k == 1) ? 5 : 2;
  endfunction

  // Forward PRESENT S-box layer, independent of the DUT's inverse table.
  function automatic logic [63:0] fwd(input logic [63:0] x);
    logic [15:0][3:0] sb;
    logic [63:0]      y;
    sb = 64'h21748FE3DA09B65C;  // index 0..F: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
    for (int i = 0; i < 16; i++) y[4*i +: 4] = sb[x[4*i +: 4]];
    return y;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Count edges from the accept edge until out_valid is seen (bounded).
  task automatic wait_out(input int k, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid[k] && lat < 40);
  endtask

  task automatic run_block(input int k, input logic [63:0] din,
                           input logic [63:0] exp, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready"}, 64'(in_ready[k]), 64'd1);
    in_valid[k] = 1'b1;
    in_data[k]  = din;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    wait_out(k, lat);
    chk({tag, " latency"}, 64'(lat), 64'(lat_of(k)));
    chk({tag, " data"}, out_data[k], exp);
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    chk({tag, " valid drop"}, 64'(out_valid[k]), 64'd0);
  endtask

  // in_ready and out_valid must never be high together.
  always @(negedge clk) begin
    for (int m = 0; m < 3; m++) begin
      vectors++;
      assert (!(in_ready[m] && out_valid[m])) else begin
        miscompares++;
        $error("FAIL state_rule lane%0d observed=%b%b expected=not 11", m, in_ready[m], out_valid[m]);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [63:0] x;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    for (int k = 0; k < 3; k++) in_data[k] = '0;

    // Reset state.
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("rst in_ready",  64'(in_ready[k]),  64'd1);
      chk("rst out_valid", 64'(out_valid[k]), 64'd0);
      chk("rst out_data",  out_data[k],       64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Reference vector and all-zero / all-one blocks on every width.
    for (int k = 0; k < 3; k++) begin
      run_block(k, 64'hC56B90AD3EF84712, 64'h0123456789ABCDEF, "ref");
      run_block(k, 64'h0000000000000000, 64'h5555555555555555, "zeros");
      run_block(k, 64'hFFFFFFFFFFFFFFFF, 64'hAAAAAAAAAAAAAAAA, "ones");
    end

    // Backpressure on LANES=4 with a new block waiting at the input.
    @(negedge clk);
    in_valid[1] = 1'b1;
    in_data[1]  = 64'h0;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    wait_out(1, lat);
    chk("bp latency", 64'(lat), 64'd5);
    in_valid[1] = 1'b1;
    in_data[1]  = 64'hFFFFFFFFFFFFFFFF;
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp hold data",  out_data[1],        64'h5555555555555555);
      chk("bp in_ready",   64'(in_ready[1]),  64'd0);
      chk("bp out_valid",  64'(out_valid[1]), 64'd1);
    end
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    out_ready[1] = 1'b0;
    chk("bp release valid", 64'(out_valid[1]), 64'd0);
    chk("bp release ready", 64'(in_ready[1]),  64'd1);
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    chk("bp accepted", 64'(in_ready[1]), 64'd0);
    wait_out(1, lat);
    chk("bp2 latency", 64'(lat), 64'd5);
    chk("bp2 data", out_data[1], 64'hAAAAAAAAAAAAAAAA);
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    out_ready[1] = 1'b0;

    // Reset during the 8th BUSY cycle of LANES=1.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 64'hC56B90AD3EF84712;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 64'(out_valid[0]), 64'd0);
    chk("midrst in_ready",  64'(in_ready[0]),  64'd1);
    chk("midrst out_data",  out_data[0],       64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(0, 64'hC56B90AD3EF84712, 64'h0123456789ABCDEF, "post_rst");

    // Round trip through the forward layer on random blocks.
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom};
      run_block(i % 3, fwd(x), x, "roundtrip");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
